// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (MULT/MULTU, DIV/DIVU)
// Divider datapath is present only when MULTDIV_DIVIDE_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeValue,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               in_a_neg, in_b_neg;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod;

`ifdef MULTDIV_DIVIDE_EN
    logic               is_div_q, is_div_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo, rem;

    assign accept = start && !busy;
`else
    assign accept = start && !busy && !op[1];
`endif

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign in_a_neg = !op[0] && operandA[WIDTH-1];
    assign in_b_neg = !op[0] && operandB[WIDTH-1];
    assign in_a_mag = in_a_neg ? -operandA : operandA;
    assign in_b_mag = in_b_neg ? -operandB : operandB;

    always_comb begin
        // Shift-add: upper half accumulates the multiplicand, multiplier drains out the bottom
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod     = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
`ifdef MULTDIV_DIVIDE_EN
        // Restoring divide: remainder in the upper half, quotient bits enter at the bottom
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, mag_q};
        rem_sub  = rem_sh - {1'b0, mag_q};
        div_next = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        quo      = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        step     = is_div_q ? div_next : mul_next;
        if (!is_div_q) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (b_zero_q) begin
            fin_hi = a_q;
            fin_lo = '1;
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
`else
        step   = mul_next;
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULTDIV_DIVIDE_EN
        is_div_d = is_div_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
`ifdef MULTDIV_DIVIDE_EN
                    is_div_d = op[1];
                    b_zero_d = (operandB == '0);
                    a_d      = operandA;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? in_a_mag : in_b_mag)};
                    mag_d    = op[1] ? in_b_mag : in_a_mag;
`else
                    acc_d    = {{WIDTH{1'b0}}, in_b_mag};
                    mag_d    = in_a_mag;
`endif
                end else begin
                    if (hiWrite) hi_d = writeValue;
                    if (loWrite) lo_d = writeValue;
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FINISH;
            end
            S_FINISH: begin
                hi_d    = fin_hi;
                lo_d    = fin_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULTDIV_DIVIDE_EN
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULTDIV_DIVIDE_EN
            is_div_q <= is_div_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hiWrite, loWrite;
    logic [1:0]   op;
    logic [W-1:0] operandA, operandB, writeValue;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeValue(writeValue),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: model = 64'(sa * sb);
            2'b01: model = ua * ub;
            2'b10: begin
                if (b == 0) model = {a, 32'hFFFFFFFF};
                else begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) model = {a, 32'hFFFFFFFF};
                else begin
                    q = ua / ub;
                    r = ua % ub;
                    model = {r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) check("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_hilo"}, {hi, lo}, e.res);
                check({e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Call away from the clock edge; returns 1 time unit after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input string tag);
        start = 1'b1;
        op = o;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb_q.push_back('{model(o, a, b), cyc + W + 1, tag});
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_seen"}, 64'(done), 1);
    endtask

    logic [W-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    initial begin
        logic [W-1:0] old_hi, old_lo, ra, rb;
        logic [1:0]   ro;
        reset = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
        hiWrite = 1'b0; loWrite = 1'b0; writeValue = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_hi", 64'(hi), 0);
        check("rst_lo", 64'(lo), 0);

        issue(2'b00, 32'hFFFFFFFE, 32'h00000003, 1, "mult_neg2x3");
        check("busy_after_accept", 64'(busy), 1);
        wait_done("mult_neg2x3");
        check("mult_neg2x3_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_neg2x3_lo", 64'(lo), 64'hFFFFFFFA);

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "multu_max");
        wait_done("multu_max");
        check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        check("multu_max_lo", 64'(lo), 64'h00000001);

        for (int i = 0; i < 10; i++) begin
`ifdef MULTDIV_DIVIDE_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            ra = (i % 2 == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb = (i % 3 == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            issue(ro, ra, rb, 1, "rand");
            wait_done("rand");
        end

        old_hi = hi;
        hiWrite = 1'b1; writeValue = 32'hDEADBEEF;
        issue(2'b00, 32'h00012345, 32'hFFFFF000, 1, "ignore_first");
        hiWrite = 1'b0;
        check("mthi_with_start_ignored", 64'(hi), 64'(old_hi));
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; operandA = 32'h11111111; operandB = 32'h22222222;
        hiWrite = 1'b1; writeValue = 32'hCAFEF00D;
        @(posedge clk);
        #1 start = 1'b0; hiWrite = 1'b0;
        check("busy_mid_op", 64'(busy), 1);
        check("mthi_while_busy_ignored", 64'(hi), 64'(old_hi));
        wait_done("ignore_first");
        repeat (40) @(negedge clk);
        check("no_second_op", 64'(sb_q.size()), 0);

        old_hi = hi;
        loWrite = 1'b1; writeValue = 32'h00001234;
        @(posedge clk);
        #1 loWrite = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h00001234);
        check("mtlo_hi_kept", 64'(hi), 64'(old_hi));
        hiWrite = 1'b1; loWrite = 1'b1; writeValue = 32'hA5A5A5A5;
        @(posedge clk);
        #1 hiWrite = 1'b0; loWrite = 1'b0;
        check("mthilo_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthilo_lo", 64'(lo), 64'hA5A5A5A5);

        issue(2'b00, 32'h00000003, 32'h00000005, 0, "rst_mid");
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b1; hiWrite = 1'b1; writeValue = 32'h77777777;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0; hiWrite = 1'b0;
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_hi", 64'(hi), 0);
        check("rst_mid_lo", 64'(lo), 0);
        repeat (40) @(negedge clk);
        check("rst_mid_idle", 64'(busy), 0);
        check("rst_mid_hi_late", 64'(hi), 0);

`ifdef MULTDIV_DIVIDE_EN
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1, "div_m7_2");
        wait_done("div_m7_2");
        check("div_m7_2_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_m7_2_hi", 64'(hi), 64'hFFFFFFFF);
        issue(2'b11, 32'h00000007, 32'h00000000, 1, "divu_7_0");
        wait_done("divu_7_0");
        check("divu_7_0_lo", 64'(lo), 64'hFFFFFFFF);
        check("divu_7_0_hi", 64'(hi), 64'h00000007);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, "div_ovf");
        wait_done("div_ovf");
        check("div_ovf_lo", 64'(lo), 64'h80000000);
        check("div_ovf_hi", 64'(hi), 64'h00000000);
        issue(2'b10, 32'hFFFFFFF7, 32'h00000000, 1, "div_m9_0");
        wait_done("div_m9_0");
        check("div_m9_0_hi", 64'(hi), 64'hFFFFFFF7);
`else
        hiWrite = 1'b1; loWrite = 1'b1; writeValue = 32'h0BADF00D;
        @(posedge clk);
        #1 hiWrite = 1'b0; loWrite = 1'b0;
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, "div_off");
        check("div_off_busy", 64'(busy), 0);
        issue(2'b11, 32'h00000007, 32'h00000000, 0, "divu_off");
        check("divu_off_busy", 64'(busy), 0);
        repeat (40) @(negedge clk);
        check("div_off_hi", 64'(hi), 64'h0BADF00D);
        check("div_off_lo", 64'(lo), 64'h0BADF00D);
        issue(2'b00, 32'h00000006, 32'hFFFFFFF9, 1, "mult_after_div_off");
        wait_done("mult_after_div_off");
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin the operation selected by op.
REQ-005 SHALL provide port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL provide port operandA  input  WIDTH  rs value from register-file readValueFirst; dividend or multiplicand.
REQ-007 SHALL provide port operandB  input  WIDTH  rt value from register-file readValueSecond; divisor or multiplier.
REQ-008 SHALL provide port hiWrite / loWrite  input  1 each  MTHI / MTLO strobes.
REQ-009 SHALL provide port writeValue  input  WIDTH  data for MTHI/MTLO.
REQ-010 SHALL provide port busy  output  1  operation in progress.
REQ-011 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port hi / lo  output  WIDTH each  architectural HI/LO registers, for MFHI/MFLO.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FINISH; busy = (state != IDLE).
REQ-014 SHALL accept start only when busy=0 (edge E0); operands and op latched at E0; state -> CALC, iteration counter = 0.
REQ-015 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) iteration per edge E1..E_WIDTH, on operand magnitudes; state -> FINISH at E_WIDTH.
REQ-016 SHALL at E_(WIDTH+1) apply sign correction, write hi/lo, set done=1 for exactly one cycle, state -> IDLE; latency accept->result = WIDTH+1 clocks.
REQ-017 SHALL accept a new start in the done cycle (back-to-back).
REQ-018 SHALL ignore start while busy=1; latched operands unaffected.
REQ-019 SHALL give MULT/MULTU full 2*WIDTH-bit product: hi = upper half, lo = lower half; MULT two's-complement, MULTU unsigned.
REQ-020 SHALL give DIV/DIVU lo = quotient, hi = remainder; DIV truncates toward zero, remainder takes dividend's sign.
REQ-021 SHALL on divide by zero complete with normal latency, lo = all ones, hi = operandA.
REQ-022 SHALL on DIV of most-negative / -1 give lo = most-negative, hi = 0.
REQ-023 SHALL apply hiWrite/loWrite at the next edge only when busy=0 and no start is accepted in that cycle; otherwise ignore them.
REQ-024 SHALL let hiWrite and loWrite in the same cycle both load writeValue.
REQ-025 SHALL hold hi/lo stable at all times except the FINISH edge, MTHI/MTLO, or reset.

Reset
REQ-026 SHALL on reset=1 at an edge set state IDLE, busy 0, done 0, hi 0, lo 0, counter 0.
REQ-027 SHALL let reset mid-operation abort it; no done pulse, hi/lo = 0.
REQ-028 SHALL let reset take priority over start, hiWrite, and loWrite in the same cycle.

Configuration
REQ-029 SHALL, with macro MULTDIV_DIVIDE_EN defined, implement DIV/DIVU per REQ-020..022.
REQ-030 SHALL, without MULTDIV_DIVIDE_EN, contain no divider datapath; start with op 10/11 is not accepted, busy stays 0, no done, hi/lo unchanged; MULT/MULTU unaffected.

Verification
REQ-031 SHALL cover: MULT 0xFFFFFFFE * 0x00000003 -> after 33 clocks done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL cover: MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL cover: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-034 SHALL cover: start at E0, second start and hiWrite at E5 -> both ignored, result of first op only; then MTLO 0x1234 while idle -> lo=0x00001234.
REQ-035 SHALL cover: reset at E10 of a MULT -> busy=0, done never pulses, hi=lo=0.
REQ-036 SHALL cover: without MULTDIV_DIVIDE_EN, DIV start -> busy stays 0, hi/lo unchanged.
